rv32_decode_stage: RTL

Instruction decode and operand-fetch stage of the RV32 pipeline. It accepts a fetched instruction, drives the register bank's two read addresses, and decodes the RV32I fields and immediate. It captures the bank's one-cycle-late read data, forwarding any same-time writeback, and presents a complete operand packet to execute over a valid/ready handshake.

---
 rtl/rv32_pkg.sv | 76 +++++++
 rtl/rv32_decode_stage_if.sv | 34 +++
 rtl/rv32_imm_gen.sv | 22 ++
 rtl/rv32_decode_stage.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared RV32 decode definitions: opcodes, instruction classes, immediate formats,
// decode-stage state encoding and the registered decode payload.
package rv32_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OP_IMM  = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd11
  } instr_class_e;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd5
  } imm_fmt_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } dec_state_e;

  // Decoded fields latched at accept; operands are captured separately one cycle later.
  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic              rd_we;
    logic [2:0]        funct3;
    logic              funct7b5;
    instr_class_e      cls;
    logic              illegal;
  } dec_fields_t;

  function automatic logic class_writes_rd(input instr_class_e cls);
    case (cls)
      CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_LOAD, CLS_OP_IMM, CLS_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // x0 is hardwired, so a write addressed to it never forwards.
  function automatic logic wb_hit(input logic              we,
                                  input logic [REG_AW-1:0] waddr,
                                  input logic [REG_AW-1:0] rs);
    return we && (waddr == rs) && (rs != '0);
  endfunction

endpackage

// File: rtl/rv32_decode_stage_if.sv
// Upstream instruction handshake and downstream operand-packet handshake of the decode stage.
interface rv32_decode_stage_if;

  logic                       in_valid;
  logic                       in_ready;
  logic [rv32_pkg::XLEN-1:0]  in_instr;
  logic [rv32_pkg::XLEN-1:0]  in_pc;

  logic                       out_valid;
  logic                       out_ready;
  logic [rv32_pkg::XLEN-1:0]  out_pc;
  logic [rv32_pkg::XLEN-1:0]  out_rs1_val;
  logic [rv32_pkg::XLEN-1:0]  out_rs2_val;
  logic [rv32_pkg::XLEN-1:0]  out_imm;
  logic [rv32_pkg::REG_AW-1:0] out_rd;
  logic                       out_rd_we;
  logic [2:0]                 out_funct3;
  logic                       out_funct7b5;
  logic [3:0]                 out_class;
  logic                       out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
           out_rd, out_rd_we, out_funct3, out_funct7b5, out_class, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm,
           out_rd, out_rd_we, out_funct3, out_funct7b5, out_class, out_illegal
  );

endinterface

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate extraction; every format is sign-extended to 32 bits.
module rv32_imm_gen
  import rv32_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm_c
);

  always_comb begin
    imm_c = '0;
    case (fmt)
      IMM_I: imm_c = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U: imm_c = {instr[31:12], 12'b0};
      IMM_J: imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm_c = '0;
    endcase
  end

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32 decode and operand-fetch stage: decodes at accept, captures the bank's
// one-cycle-late read data with writeback forwarding, and holds the packet for execute.
module rv32_decode_stage
  import rv32_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  rv32_decode_stage_if.slave bus,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_waddr,
  input  logic [XLEN-1:0]   wb_wdata
);

  dec_state_e        state, state_nx;
  logic              in_ready_c, out_valid_c, accept_c, capture_c;
  logic              hold1_c, hold2_c;

  dec_fields_t       dec_c, fields_q;
  imm_fmt_e          fmt_c;
  logic [XLEN-1:0]   imm_c;
  logic [6:0]        opcode_c;

  logic [REG_AW-1:0] rs1_idx_q, rs2_idx_q;
  logic              byp1_q, byp2_q;
  logic [XLEN-1:0]   byp_data_q;
  logic [XLEN-1:0]   rs1_val_q, rs2_val_q;
  logic [XLEN-1:0]   rs1_cap_c, rs2_cap_c;

  assign rf_raddr1 = bus.in_instr[19:15];
  assign rf_raddr2 = bus.in_instr[24:20];
  assign opcode_c  = bus.in_instr[6:0];

  rv32_imm_gen u_imm_gen (
    .instr (bus.in_instr),
    .fmt   (fmt_c),
    .imm_c (imm_c)
  );

  // Field decode of the instruction currently offered upstream.
  always_comb begin
    dec_c = '0;
    fmt_c = IMM_NONE;
    dec_c.cls = CLS_ILLEGAL;
    case (opcode_c)
      OPC_LUI:    begin dec_c.cls = CLS_LUI;    fmt_c = IMM_U; end
      OPC_AUIPC:  begin dec_c.cls = CLS_AUIPC;  fmt_c = IMM_U; end
      OPC_JAL:    begin dec_c.cls = CLS_JAL;    fmt_c = IMM_J; end
      OPC_JALR:   begin dec_c.cls = CLS_JALR;   fmt_c = IMM_I; end
      OPC_BRANCH: begin dec_c.cls = CLS_BRANCH; fmt_c = IMM_B; end
      OPC_LOAD:   begin dec_c.cls = CLS_LOAD;   fmt_c = IMM_I; end
      OPC_STORE:  begin dec_c.cls = CLS_STORE;  fmt_c = IMM_S; end
      OPC_OP_IMM: begin dec_c.cls = CLS_OP_IMM; fmt_c = IMM_I; end
      OPC_OP:     begin dec_c.cls = CLS_OP;     fmt_c = IMM_NONE; end
      OPC_FENCE:  begin dec_c.cls = CLS_FENCE;  fmt_c = IMM_I; end
      OPC_SYSTEM: begin dec_c.cls = CLS_SYSTEM; fmt_c = IMM_I; end
      default:    begin dec_c.cls = CLS_ILLEGAL; fmt_c = IMM_NONE; end
    endcase
    if (bus.in_instr[1:0] != 2'b11) begin
      dec_c.cls = CLS_ILLEGAL;
      fmt_c     = IMM_NONE;
    end
    dec_c.pc       = bus.in_pc;
    dec_c.rd       = bus.in_instr[11:7];
    dec_c.funct3   = bus.in_instr[14:12];
    dec_c.funct7b5 = bus.in_instr[30];
    dec_c.illegal  = (dec_c.cls == CLS_ILLEGAL);
    dec_c.rd_we    = class_writes_rd(dec_c.cls) && (dec_c.rd != '0);
    dec_c.imm      = dec_c.illegal ? '0 : imm_c;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (accept_c) state_nx = ST_FETCH;
        ST_FETCH: state_nx = ST_VALID;
        ST_VALID: if (bus.out_ready) state_nx = accept_c ? ST_FETCH : ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept_c    = 1'b0;
    capture_c   = 1'b0;
    hold1_c     = 1'b0;
    hold2_c     = 1'b0;
    in_ready_c  = reset && !flush &&
                  ((state == ST_IDLE) || ((state == ST_VALID) && bus.out_ready));
    accept_c    = bus.in_valid && in_ready_c;
    out_valid_c = (state == ST_VALID);
    capture_c   = (state == ST_FETCH);
    hold1_c     = (state == ST_VALID) && wb_hit(wb_we, wb_waddr, rs1_idx_q);
    hold2_c     = (state == ST_VALID) && wb_hit(wb_we, wb_waddr, rs2_idx_q);
  end

  // Capture priority: x0, same-edge writeback, bypass latched at accept, bank data.
  always_comb begin
    rs1_cap_c = rf_rdata1;
    if (rs1_idx_q == '0)                          rs1_cap_c = '0;
    else if (wb_hit(wb_we, wb_waddr, rs1_idx_q)) rs1_cap_c = wb_wdata;
    else if (byp1_q)                              rs1_cap_c = byp_data_q;

    rs2_cap_c = rf_rdata2;
    if (rs2_idx_q == '0)                          rs2_cap_c = '0;
    else if (wb_hit(wb_we, wb_waddr, rs2_idx_q)) rs2_cap_c = wb_wdata;
    else if (byp2_q)                              rs2_cap_c = byp_data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fields_q   <= '0;
      rs1_idx_q  <= '0;
      rs2_idx_q  <= '0;
      byp1_q     <= 1'b0;
      byp2_q     <= 1'b0;
      byp_data_q <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
    end else begin
      if (accept_c) begin
        fields_q   <= dec_c;
        rs1_idx_q  <= rf_raddr1;
        rs2_idx_q  <= rf_raddr2;
        byp1_q     <= wb_hit(wb_we, wb_waddr, rf_raddr1);
        byp2_q     <= wb_hit(wb_we, wb_waddr, rf_raddr2);
        byp_data_q <= wb_wdata;
      end
      if (capture_c)    rs1_val_q <= rs1_cap_c;
      else if (hold1_c) rs1_val_q <= wb_wdata;
      if (capture_c)    rs2_val_q <= rs2_cap_c;
      else if (hold2_c) rs2_val_q <= wb_wdata;
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.out_valid    = out_valid_c;
  assign bus.out_pc       = fields_q.pc;
  assign bus.out_rs1_val  = rs1_val_q;
  assign bus.out_rs2_val  = rs2_val_q;
  assign bus.out_imm      = fields_q.imm;
  assign bus.out_rd       = fields_q.rd;
  assign bus.out_rd_we    = fields_q.rd_we;
  assign bus.out_funct3   = fields_q.funct3;
  assign bus.out_funct7b5 = fields_q.funct7b5;
  assign bus.out_class    = fields_q.cls;
  assign bus.out_illegal  = fields_q.illegal;

endmodule
